dmem_arbiter: RTL and testbench

//  Two-port round-robin arbiter in front of the shared data_mem of the dual-core.

---
 rtl/dmem_arb_pkg.sv | 48 ++++
 rtl/dmem_reservation.sv | 39 +++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the dual-core data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WORD_W = 30;

    typedef enum logic [1:0] {
        AMO_NONE = 2'b00,
        AMO_LR   = 2'b01,
        AMO_SC   = 2'b10,
        AMO_RSV  = 2'b11
    } amo_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        RSP_LOAD  = 2'b00,
        RSP_STORE = 2'b01,
        RSP_SC    = 2'b10
    } rsp_kind_e;

    typedef struct packed {
        logic      valid;
        logic      owner;
        rsp_kind_e kind;
        logic      err;
        logic      sc_fail;
    } rsp_t;

    // LR/SC are always word accesses regardless of funct3.
    function automatic logic misaligned(input amo_e amo, input logic [2:0] f3,
                                        input logic [1:0] lsb);
        logic m;
        m = 1'b0;
        if (amo != AMO_NONE)
            m = (lsb != 2'b00);
        else if (f3 == F3_H || f3 == F3_HU)
            m = lsb[0];
        else if (f3 == F3_W)
            m = (lsb != 2'b00);
        return m;
    endfunction

endpackage

// File: rtl/dmem_reservation.sv
// Per-core LR.W reservation registers with write snooping from the other core.
module dmem_reservation
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        set,
    input  logic [1:0]        clear_own,
    input  logic [WORD_W-1:0] word,
    input  logic              snoop_we,
    input  logic              snoop_id,
    output logic [1:0]        match
);

    logic [1:0]             valid_q;
    logic [1:0][WORD_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            word_q  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (set[c]) begin
                    valid_q[c] <= 1'b1;
                    word_q[c]  <= word;
                end else if (clear_own[c]) begin
                    valid_q[c] <= 1'b0;
                end else if (snoop_we && snoop_id != 1'(c) && word_q[c] == word) begin
                    valid_q[c] <= 1'b0;
                end
            end
        end
    end

    assign match[0] = valid_q[0] && (word_q[0] == word);
    assign match[1] = valid_q[1] && (word_q[1] == word);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-core arbiter in front of data_mem with alignment/range checks
// and LR.W/SC.W support; responses return one cycle after the grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           core_req,
    input  logic [1:0]           core_we,
    input  logic [1:0][1:0]      core_amo,
    input  logic [1:0][XLEN-1:0] core_addr,
    input  logic [1:0][XLEN-1:0] core_wdata,
    input  logic [1:0][2:0]      core_funct3,
    output logic [1:0]           core_gnt,
    output logic [1:0]           core_rsp_valid,
    output logic [1:0][XLEN-1:0] core_rsp_data,
    output logic [1:0]           core_rsp_err,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [XLEN-1:0]      mem_address,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_rdata
);

    logic            last_gnt;
    logic            win;
    logic            grant_any;
    logic [1:0]      win_oh;
    amo_e            sel_amo;
    logic            sel_we;
    logic [XLEN-1:0] sel_addr;
    logic [2:0]      sel_f3;
    logic            err;
    logic            ok;
    logic            is_load;
    logic            is_store;
    logic            is_lr;
    logic            is_sc;
    logic [1:0]      resv_match;
    logic            sc_match;
    rsp_t            rsp_q;
    logic [XLEN-1:0] rsp_word;

    // Contention goes to the core that did not win last time.
    always_comb begin
        win = 1'b0;
        if (core_req == 2'b11)
            win = ~last_gnt;
        else if (core_req[1])
            win = 1'b1;
    end

    assign grant_any = rst_n && (core_req != 2'b00);
    assign win_oh    = win ? 2'b10 : 2'b01;
    assign core_gnt  = grant_any ? win_oh : 2'b00;

    assign sel_amo  = amo_e'(core_amo[win]);
    assign sel_we   = core_we[win];
    assign sel_addr = core_addr[win];
    assign sel_f3   = core_funct3[win];

    assign err = (sel_amo == AMO_RSV)
              || (sel_addr >= 32'(DMEM_BYTES))
              || misaligned(sel_amo, sel_f3, sel_addr[1:0]);

    assign is_lr    = (sel_amo == AMO_LR);
    assign is_sc    = (sel_amo == AMO_SC);
    assign is_store = (sel_amo == AMO_NONE) && sel_we;
    assign is_load  = ((sel_amo == AMO_NONE) && !sel_we) || is_lr;
    assign sc_match = resv_match[win];
    assign ok       = grant_any && !err;

    assign mem_read    = ok && is_load;
    assign mem_write   = ok && (is_store || (is_sc && sc_match));
    assign mem_address = sel_addr;
    assign mem_wdata   = core_wdata[win];
    assign mem_funct3  = (sel_amo == AMO_NONE) ? sel_f3 : F3_W;

    dmem_reservation u_resv (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       ((ok && is_lr) ? win_oh : 2'b00),
        .clear_own ((ok && is_sc) ? win_oh : 2'b00),
        .word      (sel_addr[XLEN-1:2]),
        .snoop_we  (mem_write),
        .snoop_id  (win),
        .match     (resv_match)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_q    <= '0;
            last_gnt <= 1'b1;
        end else begin
            rsp_q.valid <= grant_any;
            if (grant_any) begin
                rsp_q.owner   <= win;
                rsp_q.kind    <= is_sc ? RSP_SC : (is_store ? RSP_STORE : RSP_LOAD);
                rsp_q.err     <= err;
                rsp_q.sc_fail <= is_sc && !sc_match;
                last_gnt      <= win;
            end
        end
    end

    // Load data is passed straight through from data_mem's registered output.
    always_comb begin
        core_rsp_valid = '0;
        core_rsp_err   = '0;
        core_rsp_data  = '0;
        rsp_word       = '0;
        if (!rsp_q.err) begin
            case (rsp_q.kind)
                RSP_LOAD: rsp_word = mem_rdata;
                RSP_SC:   rsp_word = {31'b0, rsp_q.sc_fail};
                default:  rsp_word = '0;
            endcase
        end
        if (rsp_q.valid) begin
            core_rsp_valid[rsp_q.owner] = 1'b1;
            core_rsp_err[rsp_q.owner]   = rsp_q.err;
            core_rsp_data[rsp_q.owner]  = rsp_word;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a bench-side data_mem
// and a behavioural arbitration/reservation model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [1:0]       core_req;
    logic [1:0]       core_we;
    logic [1:0][1:0]  core_amo;
    logic [1:0][31:0] core_addr;
    logic [1:0][31:0] core_wdata;
    logic [1:0][2:0]  core_funct3;
    logic [1:0]       core_gnt;
    logic [1:0]       core_rsp_valid;
    logic [1:0][31:0] core_rsp_data;
    logic [1:0]       core_rsp_err;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_wdata;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] dmem [1024];

    dmem_arbiter #(.DMEM_BYTES(4096)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_amo       (core_amo),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_funct3    (core_funct3),
        .core_gnt       (core_gnt),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_data  (core_rsp_data),
        .core_rsp_err   (core_rsp_err),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_funct3     (mem_funct3),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simplified data_mem: whole-word access, registered read data.
    always_ff @(posedge clk) begin
        if (mem_write) dmem[mem_address[11:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= dmem[mem_address[11:2]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req    = 2'b00;
        core_we     = 2'b00;
        core_amo    = '0;
        core_addr   = '0;
        core_wdata  = '0;
        core_funct3 = '0;
    endtask

    task automatic set_op(input int c, input bit we, input logic [1:0] amo,
                          input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        core_req[c]    = 1'b1;
        core_we[c]     = we;
        core_amo[c]    = amo;
        core_addr[c]   = a;
        core_wdata[c]  = d;
        core_funct3[c] = f3;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        set_op(0, 1'b0, 2'b00, 32'h10, 32'h0, F3_W);
        set_op(1, 1'b1, 2'b00, 32'h14, 32'h1, F3_W);
        #1;
        n_tests++;
        if (core_gnt !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt got=%b want=00", core_gnt);
        end
        n_tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem rd=%b wr=%b want 0/0", mem_read, mem_write);
        end
        tick();
        tick();
        n_tests++;
        if (core_rsp_valid !== 2'b00 || core_rsp_err !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp valid=%b err=%b want 00/00", core_rsp_valid, core_rsp_err);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_single_load();
        set_op(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, F3_W);
        #1;
        n_tests++;
        if (core_gnt !== 2'b01 || mem_write !== 1'b1 || mem_address !== 32'h10) begin
            n_fail++; $display("FAIL sw_setup gnt=%b wr=%b addr=%h", core_gnt, mem_write, mem_address);
        end
        tick();
        n_tests++;
        if (core_rsp_valid !== 2'b01 || core_rsp_data[0] !== 32'h0) begin
            n_fail++; $display("FAIL sw_rsp valid=%b data=%h want 01/0", core_rsp_valid, core_rsp_data[0]);
        end
        idle();
        set_op(0, 1'b0, 2'b00, 32'h10, 32'h0, F3_W);
        #1;
        n_tests++;
        if (core_gnt !== 2'b01 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL lw_grant gnt=%b rd=%b wr=%b want 01/1/0", core_gnt, mem_read, mem_write);
        end
        tick();
        idle();
        n_tests++;
        if (core_rsp_valid !== 2'b01 || core_rsp_data[0] !== 32'hDEADBEEF || core_rsp_err !== 2'b00) begin
            n_fail++; $display("FAIL lw_rsp valid=%b data=%h err=%b want 01/deadbeef/00",
                               core_rsp_valid, core_rsp_data[0], core_rsp_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_op(0, 1'b0, 2'b00, 32'h10, 32'h0, F3_W);
            set_op(1, 1'b0, 2'b00, 32'h10, 32'h0, F3_W);
            #1;
            n_tests++;
            if (core_gnt !== exp_g[i]) begin
                n_fail++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, core_gnt, exp_g[i]);
            end
            tick();
            n_tests++;
            if (core_rsp_valid !== exp_g[i]) begin
                n_fail++; $display("FAIL rr_rsp[%0d] got=%b want=%b", i, core_rsp_valid, exp_g[i]);
            end
            n_tests++;
            if (core_rsp_data[i % 2] !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL rr_data[%0d] got=%h want=deadbeef", i, core_rsp_data[i % 2]);
            end
        end
        idle();
    endtask

    task automatic test_errors();
        set_op(1, 1'b0, 2'b00, 32'h21, 32'h0, F3_H);
        #1;
        n_tests++;
        if (core_gnt !== 2'b10 || mem_read !== 1'b0) begin
            n_fail++; $display("FAIL lh_mis_grant gnt=%b rd=%b want 10/0", core_gnt, mem_read);
        end
        tick();
        idle();
        n_tests++;
        if (core_rsp_err !== 2'b10 || core_rsp_valid !== 2'b10 || core_rsp_data[1] !== 32'h0) begin
            n_fail++; $display("FAIL lh_mis_rsp err=%b valid=%b data=%h want 10/10/0",
                               core_rsp_err, core_rsp_valid, core_rsp_data[1]);
        end
        set_op(0, 1'b1, 2'b00, 32'h1000, 32'h5, F3_W);
        #1;
        n_tests++;
        if (core_gnt !== 2'b01 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL sw_oor_grant gnt=%b wr=%b want 01/0", core_gnt, mem_write);
        end
        tick();
        idle();
        n_tests++;
        if (core_rsp_err !== 2'b01) begin
            n_fail++; $display("FAIL sw_oor_rsp err=%b want 01", core_rsp_err);
        end
    endtask

    task automatic test_lr_sc();
        for (int pass = 0; pass < 2; pass++) begin
            set_op(0, 1'b0, 2'b01, 32'h40, 32'h0, F3_B);
            #1;
            n_tests++;
            if (mem_read !== 1'b1 || mem_funct3 !== 3'b010) begin
                n_fail++; $display("FAIL lr_mem rd=%b f3=%b want 1/010", mem_read, mem_funct3);
            end
            tick();
            idle();
            if (pass == 0) begin
                set_op(1, 1'b1, 2'b00, 32'h40, 32'h5, F3_W);
                tick();
                idle();
            end
            set_op(0, 1'b0, 2'b10, 32'h40, 32'h7, F3_W);
            #1;
            n_tests++;
            if (mem_write !== (pass == 1)) begin
                n_fail++; $display("FAIL sc_write[%0d] got=%b want=%0d", pass, mem_write, pass);
            end
            tick();
            idle();
            n_tests++;
            if (core_rsp_data[0] !== ((pass == 0) ? 32'h1 : 32'h0)) begin
                n_fail++; $display("FAIL sc_result[%0d] got=%h want=%0d", pass, core_rsp_data[0], 1 - pass);
            end
            set_op(0, 1'b0, 2'b00, 32'h40, 32'h0, F3_W);
            tick();
            idle();
            n_tests++;
            if (core_rsp_data[0] !== ((pass == 0) ? 32'h5 : 32'h7)) begin
                n_fail++; $display("FAIL sc_mem[%0d] got=%h want=%0d", pass, core_rsp_data[0], (pass == 0) ? 5 : 7);
            end
        end
    endtask

    task automatic test_sc_mismatch();
        set_op(0, 1'b0, 2'b01, 32'h40, 32'h0, F3_W);
        tick();
        idle();
        set_op(0, 1'b0, 2'b10, 32'h44, 32'h9, F3_W);
        tick();
        idle();
        n_tests++;
        if (core_rsp_data[0] !== 32'h1) begin
            n_fail++; $display("FAIL sc_other_word got=%h want=1", core_rsp_data[0]);
        end
        set_op(0, 1'b0, 2'b10, 32'h40, 32'h9, F3_W);
        #1;
        n_tests++;
        if (mem_write !== 1'b0) begin
            n_fail++; $display("FAIL sc_cleared_write got=%b want=0", mem_write);
        end
        tick();
        idle();
        n_tests++;
        if (core_rsp_data[0] !== 32'h1) begin
            n_fail++; $display("FAIL sc_cleared got=%h want=1", core_rsp_data[0]);
        end
    endtask

    task automatic test_reset_mid_op();
        set_op(0, 1'b0, 2'b01, 32'h40, 32'h0, F3_W);
        tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (core_gnt !== 2'b00 || mem_read !== 1'b0) begin
            n_fail++; $display("FAIL midrst_gnt gnt=%b rd=%b want 00/0", core_gnt, mem_read);
        end
        tick();
        n_tests++;
        if (core_rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL midrst_rsp got=%b want=00", core_rsp_valid);
        end
        rst_n = 1'b1;
        idle();
        set_op(0, 1'b0, 2'b10, 32'h40, 32'h3, F3_W);
        set_op(1, 1'b0, 2'b00, 32'h0, 32'h0, F3_W);
        #1;
        n_tests++;
        if (core_gnt !== 2'b01 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL postrst_gnt gnt=%b wr=%b want 01/0", core_gnt, mem_write);
        end
        tick();
        idle();
        n_tests++;
        if (core_rsp_valid !== 2'b01 || core_rsp_data[0] !== 32'h1) begin
            n_fail++; $display("FAIL postrst_sc valid=%b data=%h want 01/1", core_rsp_valid, core_rsp_data[0]);
        end
    endtask

    task automatic test_random();
        bit          m_last;
        bit          m_rv [2];
        logic [29:0] m_rw [2];
        logic [31:0] ref_mem [1024];
        bit          known [1024];
        bit          hold [2];
        logic [2:0]  f3_tab [5];
        int          w;
        int          k;
        logic [31:0] a;
        logic [1:0]  amo;
        logic [2:0]  f3;
        bit          we;
        bit          err, ld, st, sc, sc_ok, exp_rd, exp_wr, chk_data;
        logic [31:0] exp_data;
        logic [1:0]  exp_gnt;
        int          widx;

        f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        do_reset();
        m_last = 1'b1;
        m_rv   = '{1'b0, 1'b0};
        m_rw   = '{30'h0, 30'h0};
        hold   = '{1'b0, 1'b0};
        for (int i = 0; i < 1024; i++) known[i] = 1'b0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (!hold[c]) begin
                    core_req[c] = ($urandom_range(0, 9) < 7);
                    core_we[c]  = 1'($urandom_range(0, 1));
                    k = $urandom_range(0, 19);
                    core_amo[c] = (k < 12) ? 2'b00 : (k < 15) ? 2'b01 : (k < 19) ? 2'b10 : 2'b11;
                    a = 32'($urandom_range(0, 15)) * 32'd4;
                    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                    if ($urandom_range(0, 24) == 0) a = 32'd4096 + 32'($urandom_range(0, 255)) * 32'd4;
                    core_addr[c]   = a;
                    core_funct3[c] = f3_tab[$urandom_range(0, 4)];
                    core_wdata[c]  = $urandom;
                end
            end

            w = -1;
            if (core_req == 2'b11) w = m_last ? 0 : 1;
            else if (core_req[0])  w = 0;
            else if (core_req[1])  w = 1;
            exp_gnt  = (w < 0) ? 2'b00 : 2'(1 << w);
            err      = 1'b0; ld = 1'b0; st = 1'b0; sc = 1'b0; sc_ok = 1'b0;
            exp_rd   = 1'b0; exp_wr = 1'b0; chk_data = 1'b0; exp_data = '0;
            a = '0; amo = '0; f3 = '0; we = 1'b0; widx = 0;
            if (w >= 0) begin
                a = core_addr[w]; amo = core_amo[w]; f3 = core_funct3[w]; we = core_we[w];
                err = (amo == 2'b11) || (a >= 32'd4096)
                   || (amo != 2'b00 && a % 4 != 0)
                   || (amo == 2'b00 && (f3 == F3_H || f3 == F3_HU) && a % 2 != 0)
                   || (amo == 2'b00 && f3 == F3_W && a % 4 != 0);
                ld    = (amo == 2'b00 && !we) || amo == 2'b01;
                st    = (amo == 2'b00 && we);
                sc    = (amo == 2'b10);
                sc_ok = sc && m_rv[w] && (m_rw[w] == a[31:2]);
                exp_rd = !err && ld;
                exp_wr = !err && (st || sc_ok);
                widx   = int'(a[11:2]);
                chk_data = 1'b1;
                if (err)      exp_data = 32'h0;
                else if (ld) begin
                    chk_data = known[widx];
                    exp_data = ref_mem[widx];
                end
                else if (sc)  exp_data = sc_ok ? 32'h0 : 32'h1;
                else          exp_data = 32'h0;
            end

            #1;
            n_tests++;
            if (core_gnt !== exp_gnt || mem_read !== exp_rd || mem_write !== exp_wr) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d] gnt=%b/%b rd=%b/%b wr=%b/%b", cyc,
                                   core_gnt, exp_gnt, mem_read, exp_rd, mem_write, exp_wr);
            end
            if (exp_wr) begin
                n_tests++;
                if (mem_address !== a || mem_wdata !== core_wdata[w]) begin
                    n_fail++; $display("FAIL rnd_wbus[%0d] addr=%h want=%h data=%h want=%h", cyc,
                                       mem_address, a, mem_wdata, core_wdata[w]);
                end
            end
            if (exp_rd || exp_wr) begin
                n_tests++;
                if (mem_funct3 !== ((amo == 2'b00) ? f3 : 3'b010)) begin
                    n_fail++; $display("FAIL rnd_f3[%0d] got=%b amo=%b f3=%b", cyc, mem_funct3, amo, f3);
                end
            end

            if (w >= 0) begin
                m_last = (w == 1);
                if (!err) begin
                    if (amo == 2'b01) begin
                        m_rv[w] = 1'b1;
                        m_rw[w] = a[31:2];
                    end
                    if (sc) m_rv[w] = 1'b0;
                    if (exp_wr) begin
                        ref_mem[widx] = core_wdata[w];
                        known[widx]   = 1'b1;
                        if (m_rv[1 - w] && m_rw[1 - w] == a[31:2]) m_rv[1 - w] = 1'b0;
                    end
                end
            end
            for (int c = 0; c < 2; c++) hold[c] = core_req[c] && (w != c);

            tick();
            n_tests++;
            if (core_rsp_valid !== exp_gnt) begin
                n_fail++; $display("FAIL rnd_rsp_valid[%0d] got=%b want=%b", cyc, core_rsp_valid, exp_gnt);
            end
            if (w >= 0) begin
                n_tests++;
                if (core_rsp_err[w] !== err) begin
                    n_fail++; $display("FAIL rnd_rsp_err[%0d] got=%b want=%b", cyc, core_rsp_err[w], err);
                end
                if (chk_data) begin
                    n_tests++;
                    if (core_rsp_data[w] !== exp_data) begin
                        n_fail++; $display("FAIL rnd_rsp_data[%0d] core%0d got=%h want=%h", cyc, w,
                                           core_rsp_data[w], exp_data);
                    end
                end
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_single_load();
        test_back_to_back();
        test_errors();
        test_lr_sc();
        test_sc_mismatch();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
